// File: rtl/bitcoin_nonce_scanner.sv
// bitcoin_nonce_scanner: sweeps an inclusive nonce range over NUM_CORES parallel
// double-SHA-256 lanes. One SHA-256 round per cycle. The header midstate is
// precomputed. Each batch runs LOAD, 64 inner rounds, 64 outer rounds, then CHECK.
module bitcoin_nonce_scanner #(
  parameter int NUM_CORES     = 4,
  parameter bit STOP_ON_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [255:0] midstate,
  input  logic [95:0]  tail,
  input  logic [255:0] target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  cur_nonce,
  output logic         exhausted,
  output logic         done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_R1, S_R2, S_CHECK} state_t;

  localparam logic [32:0]  NC33 = 33'(NUM_CORES);
  localparam logic [255:0] IV   =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Reverse the 32 bytes so the digest reads as the conventional block-hash value.
  function automatic logic [255:0] brev256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  // Per-word modulo-2^32 addition of two 8-word states.
  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  // One SHA-256 round; word A lives in [255:224], word H in [31:0].
  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  state_t         state_q;
  logic [5:0]     rnd_q;
  logic [31:0]    base_q;
  logic [32:0]    remaining_q;
  logic [255:0]   mid_q, target_q;
  logic [95:0]    tail_q;

  // Per-lane working variables, 16-word schedule window (W[t] in [511:480]) and outer digest.
  logic [255:0]   wv_q      [NUM_CORES];
  logic [511:0]   w_q       [NUM_CORES];
  logic [255:0]   dig_q     [NUM_CORES];
  logic [255:0]   round_out [NUM_CORES];
  logic [511:0]   w_next    [NUM_CORES];
  logic [255:0]   lane_hash [NUM_CORES];
  logic [NUM_CORES-1:0] hit;

  logic           any_hit;
  logic [31:0]    win_idx;
  logic [255:0]   win_hash;

  // Per-lane round datapath, schedule expansion and target comparison.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      round_out[i] = sha_round(wv_q[i], K[rnd_q], w_q[i][511:480]);
      w_next[i]    = {w_q[i][479:0], ssig1(w_q[i][63:32]) + w_q[i][223:192] +
                      ssig0(w_q[i][479:448]) + w_q[i][511:480]};
      lane_hash[i] = brev256(dig_q[i]);
      hit[i]       = (lane_hash[i] <= target_q) && (33'(i) < remaining_q);
    end
  end

  // Lowest-index hitting lane wins the batch.
  always_comb begin
    any_hit  = 1'b0;
    win_idx  = '0;
    win_hash = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        win_idx  = 32'(i);
        win_hash = lane_hash[i];
      end
    end
  end

  // Datapath registers: work latch, message loading and round state (no reset needed).
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      mid_q    <= midstate;
      tail_q   <= tail;
      target_q <= target;
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      case (state_q)
        S_LOAD: begin
          wv_q[i] <= mid_q;
          w_q[i]  <= {tail_q, bswap32(base_q + 32'(i)), 32'h8000_0000, 320'd0, 32'd640};
        end
        S_R1: begin
          if (rnd_q == 6'd63) begin
            wv_q[i] <= IV;
            w_q[i]  <= {add8(mid_q, round_out[i]), 32'h8000_0000, 192'd0, 32'd256};
          end else begin
            wv_q[i] <= round_out[i];
            w_q[i]  <= w_next[i];
          end
        end
        S_R2: begin
          wv_q[i] <= round_out[i];
          w_q[i]  <= w_next[i];
          if (rnd_q == 6'd63) dig_q[i] <= add8(IV, round_out[i]);
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered status outputs; abort pre-empts every non-idle state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rnd_q       <= '0;
      base_q      <= '0;
      remaining_q <= '0;
      busy        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      cur_nonce   <= '0;
      exhausted   <= 1'b0;
      done        <= 1'b0;
    end else begin
      found <= 1'b0;
      done  <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q <= S_IDLE;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              base_q      <= nonce_start;
              remaining_q <= {1'b0, nonce_end - nonce_start} + 33'd1;
              exhausted   <= 1'b0;
              found_nonce <= '0;
              found_hash  <= '0;
              busy        <= 1'b1;
              state_q     <= S_LOAD;
            end
          end
          S_LOAD: begin
            cur_nonce <= base_q;
            rnd_q     <= '0;
            state_q   <= S_R1;
          end
          S_R1: begin
            rnd_q <= rnd_q + 6'd1;
            if (rnd_q == 6'd63) state_q <= S_R2;
          end
          S_R2: begin
            rnd_q <= rnd_q + 6'd1;
            if (rnd_q == 6'd63) state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (any_hit) begin
              found       <= 1'b1;
              found_nonce <= base_q + win_idx;
              found_hash  <= win_hash;
            end
            remaining_q <= (remaining_q > NC33) ? remaining_q - NC33 : 33'd0;
            base_q      <= base_q + 32'(NUM_CORES);
            if (any_hit && STOP_ON_FIRST) begin
              state_q <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (remaining_q <= NC33) begin
              state_q   <= S_IDLE;
              busy      <= 1'b0;
              exhausted <= 1'b1;
              done      <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/bitcoin_nonce_scanner.md
# bitcoin_nonce_scanner

Parametrised successor to the double-SHA-256 block: takes a precomputed header midstate plus the 12-byte header tail, and sweeps an inclusive nonce range. NUM_CORES lanes each run an in-house 64-round SHA-256 engine, one round per cycle. Each lane does the second header compression and then the outer hash, and compares the result against a 256-bit target. It sits between the work-distribution logic and the share-reporting path, and reports either the first hit or every hit, per STOP_ON_FIRST.

## Interface
- NUM_CORES, 4, parallel lanes; legal values 1, 2, 4 or 8; lane i hashes nonce base+i
- STOP_ON_FIRST, 1, 1: scan ends at first batch with a hit; 0: report hit and keep scanning
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse; samples all work inputs; ignored while busy=1
- abort  in  1  ends an active scan at the next edge
- midstate  in  256  SHA-256 state after header bytes 0..63; word A in [255:224]
- tail  in  96  header bytes 64..75; byte 64 in [95:88]
- target  in  256  unsigned threshold
- nonce_start  in  32  first nonce (inclusive)
- nonce_end  in  32  last nonce (inclusive)
- busy  out  1  scan active
- found  out  1  1-cycle pulse: hit in this batch
- found_nonce  out  32  hit nonce, held until next hit or start
- found_hash  out  256  byte-reversed double-SHA-256 of the hit header, held like found_nonce
- cur_nonce  out  32  base nonce of the batch in flight
- exhausted  out  1  level: last scan ended by covering the whole range
- done  out  1  1-cycle pulse: scan ended for any reason

## Operation
- States: IDLE, LOAD, R1, R2, CHECK.
- IDLE→LOAD on start:
  - latch inputs
  - remaining = ((nonce_end − nonce_start) mod 2^32) + 1, a 33-bit count; start==end+1 gives 2^32
  - clear exhausted, found_nonce and found_hash
- Block 2 message, W0..W15:
  - W0..W2 = tail words
  - W3 = byteswap(nonce), since the header stores the nonce little-endian
  - W4 = 0x80000000, W5..W14 = 0, W15 = 640
- LOAD (1 cycle): working vars = midstate, schedule = block 2.
- R1 (64 cycles): compression 1.
- Leaving R1: D1 = midstate + working vars (per word, mod 2^32). Outer block = D1 words, then 0x80000000, zeros, and W15 = 256. Working vars = SHA-256 IV.
- R2 (64 cycles): compression 2; D2 = IV + working vars.
- CHECK (1 cycle):
  - H = byte-reverse of the 32-byte D2; lane hits iff H ≤ target (unsigned)
  - lanes with index ≥ remaining are masked
  - on any hit: lowest-index hitting lane wins; found pulses; found_nonce/found_hash update
- After CHECK:
  - remaining −= min(NUM_CORES, remaining); base += NUM_CORES (mod 2^32, wraps 0xFFFFFFFF→0)
  - hit and STOP_ON_FIRST=1 → IDLE, done pulse
  - else remaining==0 → IDLE, exhausted=1, done pulse
  - else → LOAD
- Abort (any non-IDLE state): IDLE at next edge; done pulse; found not asserted; exhausted stays 0; the partial batch is discarded.
- start coincident with abort while busy: abort wins; start is ignored.

## Timing
- Reset values: all outputs 0; state IDLE. Reset mid-scan: immediate IDLE, no done pulse.
- busy rises the cycle after start and falls in the same cycle done pulses.
- Batch = 130 cycles (LOAD 1 + R1 64 + R2 64 + CHECK 1).
- found and done are registered out of CHECK, so both are visible at batch-cycle 131 counted from LOAD.
- Scan of k batches: done is visible 130·k + 1 cycles after the start edge.
- cur_nonce updates at each LOAD.
- A new start is accepted the cycle after done.

## Test plan
- Genesis hit:
  - stimulus: midstate and tail of block 0 from the software model; range 0x7C2BAC1A..0x7C2BAC21; target 0x00000000FFFF followed by 208 zero bits; NUM_CORES=4
  - response: found after batch 1 (lane 3); found_nonce=0x7C2BAC1D; found_hash=000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f; done at cycle 131; exhausted=0
- Miss / exhaust:
  - stimulus: same header, range 0..9, target 0, NUM_CORES=4
  - response: 3 batches; lanes 2–3 masked in the last batch; exhausted=1; done at cycle 391; found never pulses
- Multi-hit:
  - stimulus: target all-ones, STOP_ON_FIRST=0, range 5..12
  - response: found pulses twice, found_nonce 5 then 9; done with exhausted=1; every H matches the model
- Wrap-around:
  - stimulus: range 0xFFFFFFFE..0x00000001, NUM_CORES=2, target all-ones, STOP_ON_FIRST=0
  - response: cur_nonce goes 0xFFFFFFFE then 0x00000000; found_nonce 0xFFFFFFFE then 0x00000000; 2 batches
- Abort and restart:
  - stimulus: abort at cycle 70 of a long scan; restart next cycle
  - response: done pulse, found=0, exhausted=0; the new scan gives correct results
- Reset mid-scan and start while busy:
  - stimulus: drive rst low in R2; separately pulse start while busy
  - response: on reset, outputs zero immediately and no done pulse; the start while busy has no effect
